// File: rtl/meas_sequencer.sv
// meas_sequencer
//   Measurement sequencer between the bisection search engine and the analog
//   front end. A candidate i_ref code is loaded into the DAC, allowed to settle,
//   then 2^AVG_LOG2 ADC conversions are triggered and averaged into one
//   measured Q returned over a valid/ready handshake.
//
// Optional feature macro: MEAS_SEQ_SKIP_SETTLE_EN
//   When defined, a request whose code equals the code already driven on the
//   DAC (with no reset since that load) skips LOAD/SETTLE and starts converting
//   immediately.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake, req_i_ref = candidate code
//   dac_code, dac_load    registered DAC code and one-cycle latch strobe
//   adc_start             one-cycle conversion start strobe
//   adc_done, adc_data    conversion complete and its result
//   meas_valid/meas_ready result handshake, meas_q = averaged Q
//   meas_err              result produced by a conversion timeout
//   busy                  high in every state except IDLE
module meas_sequencer #(
  parameter int WIDTH         = 10,
  parameter int SETTLE_CYCLES = 16,
  parameter int AVG_LOG2      = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_i_ref,
  output logic [WIDTH-1:0] dac_code,
  output logic             dac_load,
  output logic             adc_start,
  input  logic             adc_done,
  input  logic [WIDTH-1:0] adc_data,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [WIDTH-1:0] meas_q,
  output logic             meas_err,
  output logic             busy
);

  localparam int ACCW  = WIDTH + AVG_LOG2;
  localparam int SCW   = AVG_LOG2 + 1;
  localparam int NSAMP = 1 << AVG_LOG2;
  localparam int STW   = $clog2(SETTLE_CYCLES + 2);
  localparam int TOW   = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_START, S_WAIT, S_OUT
  } state_t;

  state_t          state;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] acc_sum;
  logic [ACCW-1:0] acc_avg;
  logic [SCW-1:0]  sample_cnt;
  logic [STW-1:0]  settle_cnt;
  logic [TOW-1:0]  tcnt;
  logic [TOW-1:0]  tcnt_nxt;
  logic            timeout_hit;
  logic            last_sample;
`ifdef MEAS_SEQ_SKIP_SETTLE_EN
  logic            code_valid;
`endif

  always_comb begin
    acc_sum     = acc + ACCW'(adc_data);
    acc_avg     = acc_sum >> AVG_LOG2;
    tcnt_nxt    = tcnt + TOW'(1);
    // Counter stops at TIMEOUT, which TOW is sized to hold, so it never wraps.
    timeout_hit = (tcnt_nxt >= TOW'(TIMEOUT));
    last_sample = (sample_cnt == SCW'(NSAMP - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      sample_cnt <= '0;
      settle_cnt <= '0;
      tcnt       <= '0;
      dac_code   <= '0;
      dac_load   <= 1'b0;
      adc_start  <= 1'b0;
      req_ready  <= 1'b0;
      meas_valid <= 1'b0;
      meas_q     <= '0;
      meas_err   <= 1'b0;
      busy       <= 1'b0;
`ifdef MEAS_SEQ_SKIP_SETTLE_EN
      code_valid <= 1'b0;
`endif
    end else begin
      dac_load  <= 1'b0;
      adc_start <= 1'b0;
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          if (req_valid && req_ready) begin
            dac_code   <= req_i_ref;
            acc        <= '0;
            sample_cnt <= '0;
            meas_err   <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
`ifdef MEAS_SEQ_SKIP_SETTLE_EN
            // DAC already holds this code and has settled: convert right away.
            if (code_valid && (req_i_ref == dac_code)) begin
              state     <= S_START;
              adc_start <= 1'b1;
            end else begin
              state    <= S_LOAD;
              dac_load <= 1'b1;
            end
            code_valid <= 1'b1;
`else
            state    <= S_LOAD;
            dac_load <= 1'b1;
`endif
          end
        end
        S_LOAD: begin
          if (SETTLE_CYCLES == 0) begin
            state     <= S_START;
            adc_start <= 1'b1;
          end else begin
            state      <= S_SETTLE;
            settle_cnt <= STW'(SETTLE_CYCLES);
          end
        end
        S_SETTLE: begin
          if (settle_cnt <= STW'(1)) begin
            state     <= S_START;
            adc_start <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - STW'(1);
          end
        end
        S_START: begin
          state <= S_WAIT;
          tcnt  <= '0;
        end
        S_WAIT: begin
          if (adc_done) begin
            acc        <= acc_sum;
            sample_cnt <= sample_cnt + SCW'(1);
            if (last_sample) begin
              state      <= S_OUT;
              meas_valid <= 1'b1;
              meas_q     <= acc_avg[WIDTH-1:0];
            end else begin
              state     <= S_START;
              adc_start <= 1'b1;
            end
          end else if (timeout_hit) begin
            tcnt       <= tcnt_nxt;
            state      <= S_OUT;
            meas_valid <= 1'b1;
            meas_q     <= '1;
            meas_err   <= 1'b1;
          end else begin
            tcnt <= tcnt_nxt;
          end
        end
        S_OUT: begin
          if (meas_ready) begin
            state      <= S_IDLE;
            meas_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
